// File: rtl/serial_adder_seq_if.sv
// Handshake and data bundle for the bit-serial adder.
// The ovf field exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_seq_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output start, a_in, b_in, cin,
        input  busy, done, sum_out, cout, ovf
    );
    modport slave (
        input  start, a_in, b_in, cin,
        output busy, done, sum_out, cout, ovf
    );
`else
    modport master (
        output start, a_in, b_in, cin,
        input  busy, done, sum_out, cout
    );
    modport slave (
        input  start, a_in, b_in, cin,
        output busy, done, sum_out, cout
    );
`endif
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output (ovf).
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    serial_adder_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    count;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             s_bit;
    logic             c_next;
    logic             accept;
    logic             last_bit;
`ifdef SERIAL_ADDER_OVF_EN
    logic             c_msb;
    logic             ovf_r;
`endif

    assign s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_next   = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign last_bit = (count == CW'(WIDTH - 1));

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.sum_out = sum_r;
    assign bus.cout    = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf     = ovf_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            c_msb  <= 1'b0;
            ovf_r  <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                    end
                end
                RUN: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
                    carry  <= c_next;
                    count  <= count + CW'(1);
`ifdef SERIAL_ADDER_OVF_EN
                    // carry entering the MSB cell, for signed overflow
                    if (last_bit) c_msb <= carry;
`endif
                    if (last_bit) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                    end
                end
                DONE: begin
                    done_r <= 1'b1;
                    sum_r  <= sum_sr;
                    cout_r <= carry;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_r  <= c_msb ^ carry;
`endif
                    if (bus.start) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                    end else begin
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
            // operand capture happens after the result copy above
            if (accept) begin
                a_sr  <= bus.a_in;
                b_sr  <= bus.b_in;
                carry <= bus.cin;
                count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed-vector bench for serial_adder_seq (WIDTH=8).
// Checks ovf too when built with SERIAL_ADDER_OVF_EN.
module tb_serial_adder_seq;
    localparam int W = 8;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    vec_t vecs [10];

    serial_adder_seq_if #(.WIDTH(W)) bus ();

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic c, output logic [7:0] s,
                          output logic co, output logic o);
        logic [7:0] prev_s;
        logic       prev_c;
        int         lat;
        int         busy_n;
        logic       stable;
        prev_s      = bus.sum_out;
        prev_c      = bus.cout;
        bus.start   = 1'b1;
        bus.a_in    = a;
        bus.b_in    = b;
        bus.cin     = c;
        tick();
        bus.start   = 1'b0;
        bus.a_in    = 8'($urandom);
        bus.b_in    = 8'($urandom);
        bus.cin     = 1'($urandom);
        lat         = 0;
        busy_n      = 0;
        stable      = 1'b1;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_n++;
            if (bus.sum_out !== prev_s || bus.cout !== prev_c)
                stable = 1'b0;
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(W + 1));
        check("busy_cycles", 32'(busy_n), 32'(W));
        check("hold_while_run", 32'(stable), 32'd1);
        s  = bus.sum_out;
        co = bus.cout;
`ifdef SERIAL_ADDER_OVF_EN
        o  = bus.ovf;
`else
        o  = 1'b0;
`endif
        tick();
        check("done_width", 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [7:0] s;
        logic       co;
        logic       o;
        logic [8:0] exp9;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        int         lat;
        int         done_n;

        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[7] = '{8'h3C, 8'hC4, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[8] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[9] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a_in  = 8'hFF;
        bus.b_in  = 8'hFF;
        bus.cin   = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum_out), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        bus.start = 1'b0;
        rst       = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, o);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].cout));
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].ovf));
`endif
        end

        for (int i = 0; i < 150; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            exp9 = 9'(ra) + 9'(rb) + 9'(rc);
            run_op(ra, rb, rc, s, co, o);
            check("rand_sum", 32'({co, s}), 32'(exp9));
        end

        // start held through RUN, then chained from the DONE cycle
        bus.start = 1'b1;
        bus.a_in  = 8'h11;
        bus.b_in  = 8'h22;
        bus.cin   = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            bus.a_in = 8'($urandom);
            bus.b_in = 8'($urandom);
            bus.cin  = 1'($urandom);
            tick();
        end
        bus.a_in = 8'($urandom);
        bus.b_in = 8'($urandom);
        tick();
        check("chain_done_early", 32'(bus.done), 32'd0);
        check("chain_busy_in_done", 32'(bus.busy), 32'd0);
        bus.a_in = 8'h70;
        bus.b_in = 8'h0F;
        bus.cin  = 1'b1;
        tick();
        bus.start = 1'b0;
        check("chain_done1", 32'(bus.done), 32'd1);
        check("chain_sum1", 32'(bus.sum_out), 32'h33);
        check("chain_cout1", 32'(bus.cout), 32'd0);
        check("chain_no_gap", 32'(bus.busy), 32'd1);
        lat = 0;
        tick();
        lat++;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
        check("chain_latency2", 32'(lat), 32'(W + 1));
        check("chain_sum2", 32'(bus.sum_out), 32'h80);
        check("chain_cout2", 32'(bus.cout), 32'd0);
        tick();

        // reset on the 4th RUN edge aborts the op
        run_op(8'h12, 8'h34, 1'b0, s, co, o);
        check("pre_rst_sum", 32'(s), 32'h46);
        bus.start = 1'b1;
        bus.a_in  = 8'hFF;
        bus.b_in  = 8'h01;
        bus.cin   = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum", 32'(bus.sum_out), 32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        done_n = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done) done_n++;
            tick();
        end
        check("abort_no_done", 32'(done_n), 32'd0);
        run_op(8'h5A, 8'h21, 1'b1, s, co, o);
        check("post_rst_sum", 32'(s), 32'h7C);
        check("post_rst_cout", 32'(co), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
